// File: rtl/segre_m_ext_pipeline.sv
// segre_m_ext_pipeline
// Five-stage fixed-latency RV32M multiply pipeline (M1..M5).
// M1 registers the issue and the operands, already extended to 33 bits.
// M2..M4 each add one 8-bit slice of operand B into a running accumulator.
// M5 adds the top, signed 9-bit slice and holds the selected 32-bit result.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   valid_m1_i, m1_*       issue interface from decode
//   stall_i, flush_i       freeze all stages / kill all in-flight ops
//   stage_valid_o          per-stage valid bits, bit0 = M1
//   stage_waddr_o          per-stage rd, M1 in the LSBs
//   m5_rf_we_o             register-file write strobe
//   m5_rf_waddr_o          write address
//   m5_rd_data_o           result, also the M5 bypass source
//   m5_illegal_o           non-multiply opcode reached M5

package segre_m_ext_pkg;
    localparam int WORD_SIZE = 32;
    localparam int REG_SIZE  = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_ext_opcode_e;
endpackage

module segre_m_ext_pipeline
    import segre_m_ext_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CHUNK_W    = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             valid_m1_i,
    input  m_ext_opcode_e                    m1_opcode_i,
    input  logic                             m1_rf_we_i,
    input  logic [REG_SIZE-1:0]              m1_rf_waddr_i,
    input  logic [WORD_SIZE-1:0]             m1_rf_src_a_i,
    input  logic [WORD_SIZE-1:0]             m1_rf_src_b_i,
    input  logic                             stall_i,
    input  logic                             flush_i,
    output logic [NUM_STAGES-1:0]            stage_valid_o,
    output logic [NUM_STAGES*REG_SIZE-1:0]   stage_waddr_o,
    output logic                             m5_rf_we_o,
    output logic [REG_SIZE-1:0]              m5_rf_waddr_o,
    output logic [WORD_SIZE-1:0]             m5_rd_data_o,
    output logic                             m5_illegal_o
);

    logic [NUM_STAGES-1:0] r_valid;
    m_ext_opcode_e         r_op    [NUM_STAGES];
    logic                  r_we    [NUM_STAGES];
    logic [REG_SIZE-1:0]   r_waddr [NUM_STAGES];

    // Operand A travels to M4; operand B sheds the slices already consumed.
    logic [32:0]           r_a1, r_a2, r_a3, r_a4;
    logic [32:0]           r_b1;
    logic [32:CHUNK_W]     r_b2;
    logic [32:2*CHUNK_W]   r_b3;
    logic [32:3*CHUNK_W]   r_b4;

    // Only the low 64 bits of the product are ever selected, and modular
    // addition makes the low 64 bits independent of anything above them.
    logic [63:0]           r_acc2, r_acc3, r_acc4;
    logic [WORD_SIZE-1:0]  r_res5;

    logic [32:0]           w_a_ext, w_b_ext;
    logic [63:0]           w_pp0, w_pp1, w_pp2, w_pp3, w_sum;
    logic                  w_legal5;

    function automatic logic [63:0] f_sext_a(input logic [32:0] a);
        return {{31{a[32]}}, a};
    endfunction

    // MULHU takes A unsigned; MULHSU and MULHU take B unsigned.
    always_comb begin
        w_a_ext = (m1_opcode_i == OP_MULHU) ? {1'b0, m1_rf_src_a_i}
                                            : {m1_rf_src_a_i[31], m1_rf_src_a_i};
        w_b_ext = (m1_opcode_i == OP_MUL || m1_opcode_i == OP_MULH)
                  ? {m1_rf_src_b_i[31], m1_rf_src_b_i}
                  : {1'b0, m1_rf_src_b_i};
    end

    // Slices 0-2 are unsigned; the top slice is a signed 9-bit value.
    always_comb begin
        w_pp0 = f_sext_a(r_a1) * 64'(r_b1[CHUNK_W-1:0]);
        w_pp1 = (f_sext_a(r_a2) * 64'(r_b2[2*CHUNK_W-1:CHUNK_W])) << CHUNK_W;
        w_pp2 = (f_sext_a(r_a3) * 64'(r_b3[3*CHUNK_W-1:2*CHUNK_W])) << (2*CHUNK_W);
        w_pp3 = (f_sext_a(r_a4) * 64'($signed(r_b4))) << (3*CHUNK_W);
        w_sum = r_acc4 + w_pp3;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_op[i]    <= OP_MUL;
                r_we[i]    <= 1'b0;
                r_waddr[i] <= '0;
            end
            r_a1   <= '0;
            r_a2   <= '0;
            r_a3   <= '0;
            r_a4   <= '0;
            r_b1   <= '0;
            r_b2   <= '0;
            r_b3   <= '0;
            r_b4   <= '0;
            r_acc2 <= '0;
            r_acc3 <= '0;
            r_acc4 <= '0;
            r_res5 <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
        end else if (!stall_i) begin
            r_valid <= {r_valid[NUM_STAGES-2:0], valid_m1_i};
            for (int i = 1; i < NUM_STAGES; i++) begin
                r_op[i]    <= r_op[i-1];
                r_we[i]    <= r_we[i-1];
                r_waddr[i] <= r_waddr[i-1];
            end
            r_op[0]    <= m1_opcode_i;
            r_we[0]    <= m1_rf_we_i;
            r_waddr[0] <= m1_rf_waddr_i;
            r_a1   <= w_a_ext;
            r_b1   <= w_b_ext;
            r_a2   <= r_a1;
            r_b2   <= r_b1[32:CHUNK_W];
            r_acc2 <= w_pp0;
            r_a3   <= r_a2;
            r_b3   <= r_b2[32:2*CHUNK_W];
            r_acc3 <= r_acc2 + w_pp1;
            r_a4   <= r_a3;
            r_b4   <= r_b3[32:3*CHUNK_W];
            r_acc4 <= r_acc3 + w_pp2;
            r_res5 <= (r_op[NUM_STAGES-2] == OP_MUL) ? w_sum[31:0] : w_sum[63:32];
        end
    end

    assign w_legal5 = (r_op[NUM_STAGES-1] == OP_MUL)    ||
                      (r_op[NUM_STAGES-1] == OP_MULH)   ||
                      (r_op[NUM_STAGES-1] == OP_MULHSU) ||
                      (r_op[NUM_STAGES-1] == OP_MULHU);

    always_comb begin
        stage_waddr_o = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_waddr_o[i*REG_SIZE +: REG_SIZE] = r_waddr[i];
        end
    end

    assign stage_valid_o = r_valid;
    assign m5_rf_we_o    = r_valid[NUM_STAGES-1] & r_we[NUM_STAGES-1] & w_legal5 &
                           (|r_waddr[NUM_STAGES-1]);
    assign m5_rf_waddr_o = r_waddr[NUM_STAGES-1];
    assign m5_rd_data_o  = (r_valid[NUM_STAGES-1] && w_legal5) ? r_res5 : '0;
    assign m5_illegal_o  = r_valid[NUM_STAGES-1] & ~w_legal5;

endmodule

// File: tb/tb_segre_m_ext_pipeline.sv
// Testbench for segre_m_ext_pipeline: directed scenarios plus a randomized
// phase, all compared against a cycle-level behavioural reference model.
module tb_segre_m_ext_pipeline;
    import segre_m_ext_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 valid_m1_i;
    m_ext_opcode_e        m1_opcode_i;
    logic                 m1_rf_we_i;
    logic [4:0]           m1_rf_waddr_i;
    logic [31:0]          m1_rf_src_a_i;
    logic [31:0]          m1_rf_src_b_i;
    logic                 stall_i;
    logic                 flush_i;
    logic [4:0]           stage_valid_o;
    logic [24:0]          stage_waddr_o;
    logic                 m5_rf_we_o;
    logic [4:0]           m5_rf_waddr_o;
    logic [31:0]          m5_rd_data_o;
    logic                 m5_illegal_o;

    segre_m_ext_pipeline dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_m1_i    (valid_m1_i),
        .m1_opcode_i   (m1_opcode_i),
        .m1_rf_we_i    (m1_rf_we_i),
        .m1_rf_waddr_i (m1_rf_waddr_i),
        .m1_rf_src_a_i (m1_rf_src_a_i),
        .m1_rf_src_b_i (m1_rf_src_b_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .stage_valid_o (stage_valid_o),
        .stage_waddr_o (stage_waddr_o),
        .m5_rf_we_o    (m5_rf_we_o),
        .m5_rf_waddr_o (m5_rf_waddr_o),
        .m5_rd_data_o  (m5_rd_data_o),
        .m5_illegal_o  (m5_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: five in-flight slots, oldest at index 4.
    bit            mv   [5];
    m_ext_opcode_e mop  [5];
    bit            mwe  [5];
    logic [4:0]    mwa  [5];
    logic [31:0]   mres [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input m_ext_opcode_e op,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MUL, OP_MULH: p = sa * sb;
            OP_MULHSU:       p = sa * ub;
            OP_MULHU:        p = ua * ub;
            default:         p = '0;
        endcase
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit is_mul(input m_ext_opcode_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) mv[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (rst_i || flush_i) begin
            model_clear();
        end else if (!stall_i) begin
            for (int i = 4; i > 0; i--) begin
                mv[i] = mv[i-1]; mop[i] = mop[i-1]; mwe[i] = mwe[i-1];
                mwa[i] = mwa[i-1]; mres[i] = mres[i-1];
            end
            mv[0]   = valid_m1_i;
            mop[0]  = m1_opcode_i;
            mwe[0]  = m1_rf_we_i;
            mwa[0]  = m1_rf_waddr_i;
            mres[0] = ref_mul(m1_opcode_i, m1_rf_src_a_i, m1_rf_src_b_i);
        end
    endtask

    task automatic check_all();
        logic [4:0] sv;
        bit legal;
        for (int i = 0; i < 5; i++) sv[i] = mv[i];
        chk("stage_valid", 64'(stage_valid_o), 64'(sv));
        for (int i = 0; i < 5; i++)
            if (mv[i]) chk("stage_waddr", 64'(stage_waddr_o[i*5 +: 5]), 64'(mwa[i]));
        legal = is_mul(mop[4]);
        chk("m5_we", 64'(m5_rf_we_o), 64'(mv[4] && mwe[4] && legal && mwa[4] != 5'd0));
        chk("m5_data", 64'(m5_rd_data_o), (mv[4] && legal) ? 64'(mres[4]) : 64'd0);
        chk("m5_illegal", 64'(m5_illegal_o), 64'(mv[4] && !legal));
        if (mv[4]) chk("m5_waddr", 64'(m5_rf_waddr_o), 64'(mwa[4]));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic issue(input m_ext_opcode_e op, input logic we, input logic [4:0] wa,
                         input logic [31:0] a, input logic [31:0] b);
        valid_m1_i = 1'b1; m1_opcode_i = op; m1_rf_we_i = we;
        m1_rf_waddr_i = wa; m1_rf_src_a_i = a; m1_rf_src_b_i = b;
    endtask

    task automatic idle();
        valid_m1_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    int lat;

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        issue(OP_MUL, 1'b0, 5'd0, 32'd0, 32'd0);
        idle();
        model_clear();
        for (int i = 0; i < 5; i++) begin
            mop[i] = OP_MUL; mwe[i] = 1'b0; mwa[i] = '0; mres[i] = '0;
        end
        #1;
        check_all();
        chk("rst_data", 64'(m5_rd_data_o), 64'd0);
        tick();
        #3 rst_i = 1'b0;

        // 1: single MUL 7*6
        issue(OP_MUL, 1'b1, 5'd3, 32'd7, 32'd6);
        tick();
        idle();
        repeat (3) tick();
        tick();
        chk("t1_data", 64'(m5_rd_data_o), 64'd42);
        chk("t1_we", 64'(m5_rf_we_o), 64'd1);
        chk("t1_waddr", 64'(m5_rf_waddr_o), 64'd3);
        tick();
        chk("t1_we_off", 64'(m5_rf_we_o), 64'd0);

        // 2: back-to-back signedness corners
        issue(OP_MULH,   1'b1, 5'd1, 32'h8000_0000, 32'h8000_0000); tick();
        chk("t2_sv1", 64'(stage_valid_o), 64'b00001);
        issue(OP_MULHSU, 1'b1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        chk("t2_sv2", 64'(stage_valid_o), 64'b00011);
        issue(OP_MULHU,  1'b1, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        chk("t2_sv3", 64'(stage_valid_o), 64'b00111);
        issue(OP_MUL,    1'b1, 5'd4, 32'h8000_0000, 32'h8000_0000); tick();
        chk("t2_sv4", 64'(stage_valid_o), 64'b01111);
        issue(OP_MUL,    1'b1, 5'd6, 32'd5, 32'hFFFF_FFFD); tick();
        chk("t2_sv5", 64'(stage_valid_o), 64'b11111);
        chk("t2_mulh", 64'(m5_rd_data_o), 64'h4000_0000);
        idle();
        tick(); chk("t2_mulhsu", 64'(m5_rd_data_o), 64'hFFFF_FFFF);
        tick(); chk("t2_mulhu",  64'(m5_rd_data_o), 64'hFFFF_FFFE);
        tick(); chk("t2_mul",    64'(m5_rd_data_o), 64'h0000_0000);
        tick(); chk("t2_mulneg", 64'(m5_rd_data_o), 64'hFFFF_FFF1);
        repeat (2) tick();

        // 3: stall three cycles with the op in M3
        issue(OP_MUL, 1'b1, 5'd7, 32'd1234, 32'd5678); tick();
        idle(); tick(); tick();
        stall_i = 1'b1;
        issue(OP_MULHU, 1'b1, 5'd9, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_frozen", 64'(stage_valid_o), 64'b00100);
        end
        stall_i = 1'b0; idle();
        lat = 0;
        while (lat < 10 && !m5_rf_we_o) begin
            tick();
            lat++;
        end
        chk("t3_lat", 64'(lat), 64'd2);
        chk("t3_data", 64'(m5_rd_data_o), 64'd7006652);
        repeat (2) tick();

        // 4: flush with stall, ops in M2 and M4
        issue(OP_MUL, 1'b1, 5'd10, 32'd11, 32'd12); tick();
        idle(); tick();
        issue(OP_MUL, 1'b1, 5'd11, 32'd13, 32'd14); tick();
        idle(); tick();
        chk("t4_pre", 64'(stage_valid_o), 64'b01010);
        flush_i = 1'b1; stall_i = 1'b1;
        issue(OP_MUL, 1'b1, 5'd12, 32'd2, 32'd2);
        tick();
        chk("t4_flushed", 64'(stage_valid_o), 64'd0);
        flush_i = 1'b0; stall_i = 1'b0; idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_no_we", 64'(m5_rf_we_o), 64'd0);
        end

        // 5: illegal opcode and write to x0
        issue(OP_DIV, 1'b1, 5'd5, 32'd100, 32'd7); tick();
        idle(); repeat (4) tick();
        chk("t5_illegal", 64'(m5_illegal_o), 64'd1);
        chk("t5_we", 64'(m5_rf_we_o), 64'd0);
        chk("t5_data", 64'(m5_rd_data_o), 64'd0);
        issue(OP_MUL, 1'b1, 5'd0, 32'd3, 32'd3); tick();
        idle(); repeat (4) tick();
        chk("t5_x0_we", 64'(m5_rf_we_o), 64'd0);
        chk("t5_x0_data", 64'(m5_rd_data_o), 64'd9);

        // 6: asynchronous reset with three ops in flight
        issue(OP_MUL,  1'b1, 5'd20, 32'd3, 32'd4); tick();
        issue(OP_MULH, 1'b1, 5'd21, 32'd5, 32'd6); tick();
        issue(OP_MULHU,1'b1, 5'd22, 32'd7, 32'd8); tick();
        idle();
        #2 rst_i = 1'b1;
        #1;
        chk("t6_sv", 64'(stage_valid_o), 64'd0);
        chk("t6_swa", 64'(stage_waddr_o), 64'd0);
        chk("t6_we", 64'(m5_rf_we_o), 64'd0);
        chk("t6_waddr", 64'(m5_rf_waddr_o), 64'd0);
        chk("t6_data", 64'(m5_rd_data_o), 64'd0);
        chk("t6_illegal", 64'(m5_illegal_o), 64'd0);
        model_clear();
        #1 rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_we", 64'(m5_rf_we_o), 64'd0);
        end

        // Randomized traffic with stalls and flushes
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0)
                issue(m_ext_opcode_e'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), pick_operand(), pick_operand());
            else
                idle();
            stall_i = ($urandom_range(0, 99) < 15);
            flush_i = ($urandom_range(0, 99) < 5);
            tick();
        end
        stall_i = 1'b0; flush_i = 1'b0; idle();
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
